fsk_frame_rx: RTL and testbench
===============================

FSK_FRAME_RX -- requirements
Module: fsk_frame_rx

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5, sync pattern preceding every frame; SHALL be nonzero.
REQ-002 Parameter SYNC_LEN, default 8, sync pattern length in bits (2..16).
REQ-003 Parameter DATA_W, default 16, payload bits per frame.
REQ-004 sysclk  input  1  system clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 bit_in  input  1  demodulated serial bit, valid when bit_stb=1.
REQ-007 bit_stb  input  1  one-cycle bit strobe; each high cycle consumes one bit.
REQ-008 word_out  output  DATA_W  last accepted payload, MSB received first.
REQ-009 word_valid  output  1  one-cycle pulse when word_out updates.
REQ-010 parity_err  output  1  one-cycle pulse on a rejected frame.
REQ-011 sync_lock  output  1  high while in DATA or PAR state.
REQ-012 frame_cnt  output  8  count of accepted frames, wraps 255->0.

Function
REQ-013 FSM states: HUNT, DATA, PAR (PAR exists only with the parity macro).
REQ-014 HUNT: on bit_stb, shift bit_in into SYNC_LEN-bit hunt register (LSB in); if the new value equals SYNC_WORD, go to DATA with bit count 0.
REQ-015 Cycles with bit_stb=0 SHALL change no state, register or counter.
REQ-016 DATA: on bit_stb, shift bit_in into DATA_W-bit data shifter; increment bit count.
REQ-017 On the DATA_W-th data strobe, go to PAR (macro defined) or HUNT (macro undefined).
REQ-018 Accepted frame: word_out loaded and word_valid=1 in the cycle after the final strobe (latency 1 cycle); frame_cnt increments in that same cycle.
REQ-019 On every return to HUNT, the hunt register SHALL be cleared to 0 so payload bits cannot form a false sync.
REQ-020 bit_stb high on consecutive cycles SHALL be treated as consecutive bits.
REQ-021 word_out SHALL hold its value between frames; rejected frames SHALL NOT modify it.
REQ-022 Bit count width SHALL be $clog2(DATA_W+1); no overflow beyond DATA_W.

Reset
REQ-023 reset asserted at any time, including mid-frame: state=HUNT, hunt register=0, data shifter=0, bit count=0, word_out=0, word_valid=0, parity_err=0, sync_lock=0, frame_cnt=0.
REQ-024 A partial frame in progress at reset SHALL be discarded without any pulse.

Configuration
REQ-025 Macro FSK_FRAME_RX_PARITY_EN defined: one extra bit follows the payload; PAR state consumes it on bit_stb; even parity over payload plus parity bit accepts the frame (REQ-018), odd rejects it with parity_err=1 for one cycle, no word_valid, and no frame_cnt change; then HUNT.
REQ-026 Macro undefined: no PAR state, no parity bit consumed, parity_err tied 0, every completed frame accepted.

Structure
REQ-027 Shared package fsk_pkg SHALL hold the FSM state enum, default SYNC_WORD/SYNC_LEN/DATA_W constants and the parity function, for reuse by the matching transmitter.
REQ-028 One sub-module, fsk_sync_detect (hunt shift register plus comparator, match pulse output), SHALL be instantiated; the FSM, counters and output registers stay in fsk_frame_rx.

Verification
REQ-029 Defaults, macro undefined: strobe bits A5 then 16'h1234 with one strobe every 16 cycles -> word_out=16'h1234, word_valid 1 cycle after the last strobe, frame_cnt=1.
REQ-030 Macro defined: A5, 16'h00FF, parity bit 0 -> accepted; same frame with parity bit 1 -> parity_err pulse, word_out unchanged, frame_cnt unchanged.
REQ-031 Preamble 0xFF 0xFF then A5 then 16'hBEEF, including back-to-back strobes -> exactly one word_valid with 16'hBEEF; sync_lock high only during the payload.
REQ-032 Payload 16'h00A5 then garbage without sync -> single frame only; no second sync from payload bits.
REQ-033 reset asserted after 7 payload bits, then a full valid frame -> no pulse for the partial frame; next frame accepted with frame_cnt=1.
REQ-034 256 back-to-back valid frames -> frame_cnt wraps to 0; word_valid count=256.

Source files
------------

// File: rtl/fsk_pkg.sv
// rtl/fsk_pkg.sv - shared FSK framing types, defaults and parity helper
//
// Shared between fsk_frame_rx and the matching transmitter so that both ends
// agree on the sync pattern, payload width, state encoding and parity rule.
//   fsk_state_t     : framer state encoding (HUNT, DATA, PAR)
//   DEF_SYNC_WORD   : default sync pattern (low DEF_SYNC_LEN bits used)
//   DEF_SYNC_LEN    : default sync pattern length in bits
//   DEF_DATA_W      : default payload width in bits
//   xor_parity()    : XOR reduction over up to PARITY_MAX_W bits
package fsk_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } fsk_state_t;

    localparam logic [15:0] DEF_SYNC_WORD = 16'h00A5;
    localparam int          DEF_SYNC_LEN  = 8;
    localparam int          DEF_DATA_W    = 16;

    // Widest payload the parity helper covers; narrower payloads are
    // zero-extended by the caller, which does not change the XOR result.
    localparam int          PARITY_MAX_W  = 64;

    // Returns 1 when an odd number of bits are set.  A frame whose payload
    // plus parity bit reduces to 0 has even parity and is accepted.
    function automatic logic xor_parity(input logic [PARITY_MAX_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/fsk_sync_detect.sv
// rtl/fsk_sync_detect.sv - serial sync-word hunter for the FSK frame receiver
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset, clears the hunt register
//   bit_in    : demodulated bit, sampled when shift_en is high
//   shift_en  : strobe qualified by the receiver being in HUNT
//   match     : combinational, high in the strobe cycle whose bit completes
//               the sync pattern
module fsk_sync_detect
    import fsk_pkg::*;
#(
    parameter int          SYNC_LEN  = DEF_SYNC_LEN,
    parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic shift_en,
    output logic match
);

    localparam logic [SYNC_LEN-1:0] PATTERN = SYNC_WORD[SYNC_LEN-1:0];

    logic [SYNC_LEN-1:0] hunt_q;
    logic [SYNC_LEN-1:0] hunt_next;

    // New bit enters at the LSB, so the oldest bit ends up in the MSB and the
    // pattern reads MSB-first exactly as it was transmitted.
    assign hunt_next = (hunt_q << 1) | SYNC_LEN'(bit_in);
    assign match     = shift_en && (hunt_next == PATTERN);

    // On a match the register is cleared instead of loaded.  It then holds 0
    // for the whole frame (shift_en is low outside HUNT), so the receiver
    // always re-enters HUNT with an empty history and payload bits can never
    // combine with stale sync bits into a false match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hunt_q <= '0;
        end else if (shift_en) begin
            hunt_q <= match ? '0 : hunt_next;
        end
    end

endmodule

// File: rtl/fsk_frame_rx.sv
// rtl/fsk_frame_rx.sv - FSK serial frame receiver: sync hunt, payload capture, optional parity
//
// Frame on the wire: SYNC_LEN sync bits, DATA_W payload bits (MSB first) and,
// when FSK_FRAME_RX_PARITY_EN is defined, one even-parity bit.
// Ports:
//   sysclk     : clock, rising edge
//   reset      : asynchronous active-high reset; drops any partial frame
//   bit_in     : demodulated bit, valid while bit_stb is high
//   bit_stb    : one bit consumed per high cycle (back-to-back allowed)
//   word_out   : last accepted payload, held between frames
//   word_valid : one-cycle pulse, cycle after the final strobe of a good frame
//   parity_err : one-cycle pulse on a parity-rejected frame (0 without macro)
//   sync_lock  : high while receiving payload or parity bit
//   frame_cnt  : accepted frame count, wraps 255 -> 0
// Build option: FSK_FRAME_RX_PARITY_EN adds the PAR state and parity check.
module fsk_frame_rx
    import fsk_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int          SYNC_LEN  = DEF_SYNC_LEN,
    parameter int          DATA_W    = DEF_DATA_W
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_stb,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    output logic              parity_err,
    output logic              sync_lock,
    output logic [7:0]        frame_cnt
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_W - 1);

    fsk_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] data_next;
    logic              sync_match;

    assign data_next = (data_sh << 1) | DATA_W'(bit_in);

    fsk_sync_detect #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detect (
        .clk      (sysclk),
        .rst      (reset),
        .bit_in   (bit_in),
        .shift_en (bit_stb && (state == ST_HUNT)),
        .match    (sync_match)
    );

`ifdef FSK_FRAME_RX_PARITY_EN
    // data_sh holds the complete payload while in PAR; the frame is good when
    // payload plus the incoming parity bit has an even number of ones.
    logic par_ok;
    assign par_ok = ~(xor_parity(PARITY_MAX_W'(data_sh)) ^ bit_in);
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= ST_HUNT;
            bit_cnt    <= '0;
            data_sh    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            sync_lock  <= 1'b0;
            frame_cnt  <= 8'd0;
`ifdef FSK_FRAME_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one cycle; everything else only moves on a
            // strobe, so idle cycles leave the frame state untouched.
            word_valid <= 1'b0;
`ifdef FSK_FRAME_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (bit_stb) begin
                case (state)
                    ST_HUNT: begin
                        if (sync_match) begin
                            state     <= ST_DATA;
                            bit_cnt   <= '0;
                            sync_lock <= 1'b1;
                        end
                    end

                    ST_DATA: begin
                        data_sh <= data_next;
                        if (bit_cnt == LAST_IDX) begin
`ifdef FSK_FRAME_RX_PARITY_EN
                            // Count reaches DATA_W here, which the counter
                            // width is sized to hold; PAR resets it.
                            state   <= ST_PAR;
                            bit_cnt <= bit_cnt + 1'b1;
`else
                            word_out   <= data_next;
                            word_valid <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            state      <= ST_HUNT;
                            bit_cnt    <= '0;
                            sync_lock  <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end

`ifdef FSK_FRAME_RX_PARITY_EN
                    ST_PAR: begin
                        if (par_ok) begin
                            word_out   <= data_sh;
                            word_valid <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                        state     <= ST_HUNT;
                        bit_cnt   <= '0;
                        sync_lock <= 1'b0;
                    end
`endif

                    default: begin
                        state     <= ST_HUNT;
                        bit_cnt   <= '0;
                        sync_lock <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsk_frame_rx.sv
// tb/tb_fsk_frame_rx.sv - scoreboard testbench for fsk_frame_rx
module tb_fsk_frame_rx;

`ifdef FSK_FRAME_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        sysclk  = 1'b0;
    logic        reset   = 1'b1;
    logic        bit_in  = 1'b0;
    logic        bit_stb = 1'b0;
    logic [15:0] word_out;
    logic        word_valid;
    logic        parity_err;
    logic        sync_lock;
    logic [7:0]  frame_cnt;

    typedef struct {
        logic        is_err;
        logic [15:0] word;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] model_word = 16'h0000;
    logic [7:0]  model_cnt  = 8'd0;
    int          n_cmp      = 0;
    int          n_bad      = 0;
    int          valid_seen = 0;
    int          base_valid;

    always #5 sysclk = ~sysclk;

    fsk_frame_rx dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_stb    (bit_stb),
        .word_out   (word_out),
        .word_valid (word_valid),
        .parity_err (parity_err),
        .sync_lock  (sync_lock),
        .frame_cnt  (frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected frame.
    always @(negedge sysclk) begin
        if (!reset && (word_valid || parity_err)) begin
            if (word_valid) valid_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: word_valid=%0b parity_err=%0b word_out=%0h, none expected (t=%0t)",
                         word_valid, parity_err, word_out, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_word_valid", 32'(word_valid), 32'(!mon_e.is_err));
                check("sb_parity_err", 32'(parity_err), 32'(mon_e.is_err));
                check("sb_word_out",   32'(word_out),   32'(mon_e.word));
                check("sb_frame_cnt",  32'(frame_cnt),  32'(mon_e.cnt));
            end
        end
    end

    // Invariant between calls: time is 1 unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit_in  = b;
        bit_stb = 1'b1;
        @(posedge sysclk);
        #1;
        bit_stb = 1'b0;
        idle(gap);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic send_frame(input logic [15:0] payload, input logic par_bit,
                              input logic exp_ok, input int gap);
        logic last;
        check("lock_before_sync", 32'(sync_lock), 32'd0);
        send_byte(8'hA5, gap);
        check("lock_after_sync", 32'(sync_lock), 32'd1);
        for (int i = 15; i >= 1; i--) send_bit(payload[i], gap);
        if (PAR_EN) begin
            send_bit(payload[0], gap);
            last = par_bit;
        end else begin
            last = payload[0];
        end
        if (exp_ok) begin
            model_cnt  = model_cnt + 8'd1;
            model_word = payload;
            exp_q.push_back('{1'b0, payload, model_cnt});
        end else begin
            exp_q.push_back('{1'b1, model_word, model_cnt});
        end
        bit_in  = last;
        bit_stb = 1'b1;
        @(posedge sysclk);
        #1;
        bit_stb = 1'b0;
        check("valid_latency", 32'(word_valid), 32'(exp_ok));
        check("lock_after_frame", 32'(sync_lock), 32'd0);
        idle(gap);
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        bit_stb = 1'b0;
        #2;
        check("rst_word_out",   32'(word_out),   32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_sync_lock",  32'(sync_lock),  32'd0);
        check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
        idle(2);
        reset      = 1'b0;
        model_cnt  = 8'd0;
        model_word = 16'h0000;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        @(posedge sysclk);
        #1;
        apply_reset();

        // One strobe every 16 cycles, payload 1234 (5 ones -> parity 1).
        send_frame(16'h1234, 1'b1, 1'b1, 15);
        check("slow_word_out",  32'(word_out),  32'h1234);
        check("slow_frame_cnt", 32'(frame_cnt), 32'd1);

        // Preamble of ones then back-to-back sync and payload (13 ones -> 1).
        base_valid = valid_seen;
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        send_frame(16'hBEEF, 1'b1, 1'b1, 0);
        idle(2);
        check("preamble_one_valid", 32'(valid_seen - base_valid), 32'd1);
        check("preamble_word_out",  32'(word_out),  32'hBEEF);

        // 00FF has 8 ones: parity 0 accepted; parity 1 rejected when enabled.
        send_frame(16'h00FF, 1'b0, 1'b1, 1);
        send_frame(16'h00FF, 1'b1, !PAR_EN, 1);
        check("par_word_out",  32'(word_out),  32'h00FF);
        check("par_frame_cnt", 32'(frame_cnt), 32'(model_cnt));

        // Payload ending in the sync pattern, then the sync suffix 00101:
        // a receiver that kept payload/sync history would falsely lock here.
        send_frame(16'h00A5, 1'b0, 1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        check("no_false_sync", 32'(sync_lock), 32'd0);
        send_byte(8'h00, 0);
        check("no_false_sync_late", 32'(sync_lock), 32'd0);

        // Reset after 7 payload bits, then a clean frame.
        send_byte(8'hA5, 1);
        for (int i = 0; i < 7; i++) send_bit(i[0], 1);
        check("partial_locked", 32'(sync_lock), 32'd1);
        apply_reset();
        idle(3);
        send_frame(16'hC3C3, 1'b0, 1'b1, 2);
        check("post_reset_cnt",  32'(frame_cnt), 32'd1);
        check("post_reset_word", 32'(word_out),  32'hC3C3);

        // 256 back-to-back frames wrap the counter to 0.
        apply_reset();
        base_valid = valid_seen;
        for (int i = 0; i < 256; i++) begin
            send_frame({i[7:0], i[7:0]}, 1'b0, 1'b1, 0);
        end
        idle(2);
        check("wrap_frame_cnt",   32'(frame_cnt), 32'd0);
        check("wrap_valid_count", 32'(valid_seen - base_valid), 32'd256);
        check("wrap_word_out",    32'(word_out),  32'hFFFF);

        idle(4);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
